// File: rtl/minirisc_run_ctrl.sv
// Run controller for the KGP-miniRISC core: streams a program image into IMEM, sequences core reset/run,
// detects halt or timeout. Optional single-step gating is compiled in with RUN_SINGLE_STEP_EN.
module minirisc_run_ctrl #(
  parameter int IMEM_AW        = 10,
  parameter int TIMEOUT_CYCLES = 1400,
  parameter int RST_HOLD       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  input  logic               start,
  input  logic               abort,
  input  logic               clear,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst,
  output logic               core_en,
  input  logic               halt_flag,
`ifdef RUN_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  input  logic [15:0]        core_out,
  output logic [15:0]        result,
  output logic [31:0]        cycle_count,
  output logic               done,
  output logic               timed_out,
  output logic               load_err,
  output logic               loaded
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RSTHOLD, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               core_rst_q, core_rst_d;
  logic               core_en_q, core_en_d;
  logic [15:0]        result_q, result_d;
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic               load_err_q, load_err_d;
  logic               loaded_q, loaded_d;

  logic hs, step_ok, run_en, at_timeout;

  always_comb begin
    load_ready = (state_q == S_IDLE);
    hs         = load_valid & load_ready;
    imem_we    = hs & ~load_err_q;
    imem_waddr = cnt_q;
    imem_wdata = load_data;
`ifdef RUN_SINGLE_STEP_EN
    step_ok    = ~step_mode | step;
`else
    step_ok    = 1'b1;
`endif
    // core_en_q marks the cycle the core actually advances; only those count toward halt/timeout
    run_en     = (state_q == S_RUN) & core_en_q;
    at_timeout = (cycle_count_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    result_d      = result_q;
    cycle_count_d = cycle_count_q;
    timed_out_d   = timed_out_q;
    load_err_d    = load_err_q;
    loaded_d      = loaded_q;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (!load_err_q) begin
            // any accepted word that is not the last leaves an incomplete image resident
            loaded_d = load_last;
            if (load_last) begin
              cnt_d = '0;
            end else if (cnt_q == {IMEM_AW{1'b1}}) begin
              load_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (start && loaded_q && !load_err_q) begin
          state_d       = S_RSTHOLD;
          hold_d        = '0;
          cycle_count_d = '0;
          timed_out_d   = 1'b0;
        end
        if (clear) begin
          load_err_d = 1'b0;
        end
      end
      S_RSTHOLD: begin
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (run_en) begin
          if (cycle_count_q != 32'hFFFF_FFFF) begin
            cycle_count_d = cycle_count_q + 32'd1;
          end
          if (halt_flag) begin
            state_d  = S_DONE;
            result_d = core_out;
          end else if (at_timeout) begin
            state_d     = S_DONE;
            timed_out_d = 1'b1;
            result_d    = core_out;
          end
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d    = S_IDLE;
          load_err_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      loaded_d   = 1'b0;
      load_err_d = 1'b0;
    end

    core_rst_d = (state_d == S_IDLE) || (state_d == S_RSTHOLD);
    core_en_d  = (state_d == S_RUN) && step_ok;
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      core_rst_q    <= 1'b1;
      core_en_q     <= 1'b0;
      result_q      <= '0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      load_err_q    <= 1'b0;
      loaded_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      core_rst_q    <= core_rst_d;
      core_en_q     <= core_en_d;
      result_q      <= result_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      timed_out_q   <= timed_out_d;
      load_err_q    <= load_err_d;
      loaded_q      <= loaded_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign core_en     = core_en_q;
  assign result      = result_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign load_err    = load_err_q;
  assign loaded      = loaded_q;

endmodule

// File: tb/tb_minirisc_run_ctrl.sv
// Scoreboard bench for minirisc_run_ctrl: IMEM writes and run completions are predicted into queues
// and checked by a monitor; the single-step test is included when RUN_SINGLE_STEP_EN is defined.
module tb_minirisc_run_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 1400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0, load_last = 1'b0, start = 1'b0, abort = 1'b0, clear = 1'b0;
  logic [31:0]   load_data = '0;
  logic          halt_flag = 1'b0;
  logic [15:0]   core_out = '0;
  logic          load_ready, imem_we, core_rst, core_en, done, timed_out, load_err, loaded;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata, cycle_count;
  logic [15:0]   result;
`ifdef RUN_SINGLE_STEP_EN
  logic          step_mode = 1'b0, step = 1'b0;
`endif

  minirisc_run_ctrl #(.IMEM_AW(AW), .TIMEOUT_CYCLES(TMO), .RST_HOLD(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .start(start), .abort(abort), .clear(clear), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_rst(core_rst), .core_en(core_en),
    .halt_flag(halt_flag),
`ifdef RUN_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .core_out(core_out), .result(result), .cycle_count(cycle_count), .done(done),
    .timed_out(timed_out), .load_err(load_err), .loaded(loaded));

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: position within current image, image status, last reported result
  int          m_n = 0;
  bit          m_loaded = 1'b0, m_err = 1'b0;
  logic [15:0] m_result = '0;

  logic [AW+31:0] wr_q[$];
  logic [48:0]    dn_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear_image();
    m_n = 0;
    m_loaded = 1'b0;
    m_err = 1'b0;
  endtask

  // monitor: pops a prediction whenever the DUT writes IMEM or raises done
  initial begin
    logic dprev;
    logic [AW+31:0] ew;
    logic [48:0] ed;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none", imem_waddr, imem_wdata);
        end else begin
          ew = wr_q.pop_front();
          chk("imem_write", 64'({imem_waddr, imem_wdata}), 64'(ew));
        end
      end
      if (done && !dprev) begin
        if (dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got result 0x%0h expected none", result);
        end else begin
          ed = dn_q.pop_front();
          chk("completion", 64'({result, cycle_count, timed_out}), 64'(ed));
        end
      end
      dprev = done;
    end
  end

  task automatic send_word(input logic [31:0] d, input bit last, input bit with_start);
    load_valid = 1'b1; load_data = d; load_last = last; start = with_start;
    if (!m_err) begin
      wr_q.push_back({AW'(m_n), d});
      m_loaded = last;
      if (last) m_n = 0;
      else if (m_n == DEPTH - 1) m_err = 1'b1;
      else m_n++;
    end
    tick(1);
    load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    chk({tag, "_core_en"}, 64'(core_en), 64'd0);
    chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_outs"}, 64'({result, done, timed_out, load_err, loaded}), 64'd0);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  // mode 0: run to halt/timeout; mode 1: abort in RUN cycle cut; mode 2: async reset in RUN cycle cut
  task automatic start_run(input int halt_at, input logic [15:0] endval, input int mode, input int cut);
    int k, rc, exp_end;
    bit fin;
    k = 0; rc = 0; fin = 1'b0;
    exp_end = (halt_at == 0 || halt_at > TMO) ? TMO : halt_at;
    if (mode == 0) begin
      dn_q.push_back({endval, 32'(exp_end), (halt_at == 0 || halt_at > TMO)});
      m_result = endval;
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      if (core_en) begin
        k++;
        if (mode == 1 && k == cut) begin
          abort = 1'b1;
          tick(1);
          abort = 1'b0;
          model_clear_image();
          fin = 1'b1;
        end else if (mode == 2 && k == cut) begin
          rst = 1'b0;
          #1;
          model_clear_image();
          m_result = '0;
          chk_reset_vals("mid_run_rst");
          tick(1);
          rst = 1'b1;
          fin = 1'b1;
        end else begin
          halt_flag = (k == halt_at);
          core_out  = (k == exp_end) ? endval : 16'($urandom);
          tick(1);
        end
      end else if (done) begin
        fin = 1'b1;
      end else begin
        if (core_rst) rc++;
        tick(1);
      end
    end
    halt_flag = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL run_bound: got no completion expected one within 3000 cycles");
    end
    chk("core_rst_hold", 64'(rc), 64'd2);
  endtask

  task automatic clear_done();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_done", 64'(done), 64'd0);
    chk("clear_core_rst", 64'(core_rst), 64'd1);
    chk("clear_loaded", 64'(loaded), 64'(m_loaded));
  endtask

  initial begin
    int len;
    int en_cnt;
    logic [15:0] v;

    tick(3);
    chk_reset_vals("por");
    chk("por_ready", 64'(load_ready), 64'd1);
    rst = 1'b1;
    tick(1);

    // image 0x11..0x44; start alongside the last handshake is ignored
    send_word(32'h11, 1'b0, 1'b0);
    send_word(32'h22, 1'b0, 1'b0);
    send_word(32'h33, 1'b0, 1'b0);
    send_word(32'h44, 1'b1, 1'b1);
    tick(4);
    chk("start_with_hs_ignored", 64'(core_en), 64'd0);
    chk("loaded_after_image", 64'({loaded, load_err}), 64'b10);

    start_run(50, 16'd120, 0, 0);
    chk("done_state", 64'({done, core_en, core_rst}), 64'b100);
    tick(3);
    chk("done_hold", 64'({result, cycle_count, timed_out}), 64'({16'd120, 32'd50, 1'b0}));
    clear_done();

    // image kept after clear: rerun straight into timeout, then halt coinciding with timeout
    start_run(0, 16'($urandom), 0, 0);
    clear_done();
    start_run(TMO, 16'($urandom), 0, 0);
    clear_done();

    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(1, DEPTH);
      for (int j = 0; j < len; j++) send_word($urandom, j == len - 1, 1'b0);
      chk("rand_loaded", 64'(loaded), 64'd1);
      start_run($urandom_range(1, 40), 16'($urandom), 0, 0);
      clear_done();
    end

    start_run(0, 16'd0, 1, 10);
    chk("abort_state", 64'({core_rst, core_en, loaded, done}), 64'b1000);
    chk("abort_result_kept", 64'(result), 64'(m_result));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    chk("start_unloaded_ignored", 64'({core_rst, core_en}), 64'b10);

    for (int j = 0; j < 6; j++) send_word(32'hA000 + 32'(j), j == 5, 1'b0);
    chk("overflow_flags", 64'({load_err, loaded}), 64'({m_err, m_loaded}));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    chk("start_err_ignored", 64'({core_rst, core_en}), 64'b10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    model_clear_image();
    chk("abort_clears_err", 64'(load_err), 64'd0);

    send_word(32'hBEEF, 1'b0, 1'b0);
    send_word(32'hCAFE, 1'b1, 1'b0);
    start_run(0, 16'd0, 2, 5);
    tick(1);

`ifdef RUN_SINGLE_STEP_EN
    send_word(32'hA5, 1'b1, 1'b0);
    step_mode = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    en_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step = (i == 1 || i == 5 || i == 9);
      tick(1);
      step = 1'b0;
      if (core_en) en_cnt++;
    end
    chk("step_en_cycles", 64'(en_cnt), 64'd3);
    chk("step_cycle_count", 64'(cycle_count), 64'd3);
    v = 16'($urandom);
    dn_q.push_back({v, 32'd4, 1'b0});
    m_result = v;
    step_mode = 1'b0;
    halt_flag = 1'b1;
    core_out = v;
    for (int i = 0; i < 10 && !done; i++) tick(1);
    halt_flag = 1'b0;
    clear_done();
`else
    en_cnt = 0;
    v = '0;
`endif

    tick(5);
    chk("writes_drained", 64'(wr_q.size()), 64'd0);
    chk("completions_drained", 64'(dn_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minirisc_run_ctrl.md
Name: minirisc_run_ctrl

Overview:
- Run controller for the KGP-miniRISC core. It sits between the bench or host and the core datapath.
- Streams a program image into instruction memory over a valid/ready interface.
- Holds the core in reset while loading, then releases it and gates execution with a clock enable.
- Detects the halt condition (bit 0 of register 16) or a cycle timeout, captures the core's `out` value and reports completion.

Parameters:
IMEM_AW, 10, instruction memory word-address width
TIMEOUT_CYCLES, 1400, maximum RUN-state cycles before a forced stop (1400 × 20 ns period = 28 µs)
RST_HOLD, 2, cycles the core reset is held after start

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
load_valid  in  1  program word valid
load_ready  out  1  controller accepts a word
load_data  in  32  instruction word
load_last  in  1  final word of the image; qualified by the handshake
start  in  1  single-cycle pulse that launches execution
abort  in  1  forces a return to IDLE from any state
clear  in  1  acknowledges DONE; returns to IDLE
imem_we  out  1  instruction memory write strobe
imem_waddr  out  IMEM_AW  instruction memory write address
imem_wdata  out  32  instruction memory write data
core_rst  out  1  active-high reset to the core
core_en  out  1  core clock enable
halt_flag  in  1  register 16, bit 0, from the datapath register file
core_out  in  16  core `out` bus
result  out  16  core_out captured at halt
cycle_count  out  32  cycles spent in RUN
done  out  1  run finished (halt or timeout)
timed_out  out  1  run ended by timeout
load_err  out  1  sticky image overflow flag
loaded  out  1  a complete image is resident

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE; core_rst=1; core_en=0; imem_we=0; address counter=0.
  - result, cycle_count, done, timed_out, load_err and loaded all =0.
- States: IDLE, RSTHOLD, RUN, DONE.
- Loading, IDLE only:
  - load_ready=1 only in IDLE. A handshake is load_valid & load_ready.
  - Each handshake drives, combinationally in the same cycle, imem_we=1, imem_waddr=counter, imem_wdata=load_data. The counter increments on the clock edge.
  - Handshake with load_last=1: loaded←1 and counter←0 on that edge.
  - First handshake after loaded=1 starts a new image: loaded←0.
  - Handshake when counter=2^IMEM_AW−1: the word is written, counter saturates and load_err←1.
  - Further words while load_err=1: accepted (load_ready stays 1) but imem_we=0, so they are dropped. load_err stays set until clear, abort or reset.
- IDLE→RSTHOLD:
  - Taken on start & loaded & ~load_err.
  - start while not loaded, or with load_err set, is ignored.
  - start in the same cycle as a load handshake: the handshake completes and start is ignored.
  - On entry: cycle_count←0, done←0, timed_out←0.
- RSTHOLD: core_rst=1 for exactly RST_HOLD cycles, then →RUN.
- RUN:
  - core_rst=0, core_en=1; cycle_count increments every cycle.
  - halt_flag=1 → DONE with result←core_out on that edge.
  - cycle_count=TIMEOUT_CYCLES−1 → DONE with timed_out←1 and result←core_out.
  - halt_flag and timeout in the same cycle: halt wins, timed_out=0.
- DONE:
  - done=1, core_en=0, core_rst=0.
  - result, cycle_count and timed_out hold their values.
  - clear → IDLE: core_rst←1, done←0, load_err←0; loaded is kept.
- abort (any state, highest priority after reset):
  - →IDLE next edge; core_en←0, core_rst←1, done←0.
  - Partial image: counter←0, loaded←0.
  - result is kept.
- Outputs are registered except the imem_* write strobe/address/data and load_ready, which are combinational from state and registered flags.
- cycle_count saturates at 2^32−1.

Optional Feature:
- Macro: RUN_SINGLE_STEP_EN.
- When defined, adds input `step_mode` (1 bit) and input `step` (1 bit, pulse).
  - In RUN with step_mode=1, core_en=1 only in the cycle after a step pulse.
  - cycle_count increments only on enabled cycles.
  - halt and timeout are evaluated only on enabled cycles.
- When undefined, neither port exists and core_en=1 throughout RUN.

Test Plan:
- Load 4 words (0x11,0x22,0x33,0x44; last on word 4) → imem writes at addresses 0..3, loaded=1, counter back to 0.
- start, then halt_flag=1 on RUN cycle 50 with core_out=16'd120 → done=1, result=120, cycle_count=50, timed_out=0. core_rst high for exactly 2 cycles after start.
- Run with halt_flag held 0 → DONE after 1400 RUN cycles, timed_out=1. Repeat with halt_flag=1 in the timeout cycle → timed_out=0.
- IMEM_AW=2, send 6 words → writes only to addresses 0..3, load_err=1. A following start is ignored (stays IDLE).
- abort at RUN cycle 10 → IDLE next cycle, core_rst=1, loaded=0. start without reload is ignored. Async rst pulse mid-RUN → all outputs return to reset values immediately.
- With RUN_SINGLE_STEP_EN and step_mode=1: 3 step pulses → core_en high for exactly 3 cycles, cycle_count=3.
